uart_rx_framer: RTL

Receive-side framing engine for the UART: oversamples the raw `rx_i` line on the 8x RX clock, detects and qualifies start bits, and deserializes 8-bit LSB-first frames with optional parity and 1 or 2 stop bits. It delivers each good byte as a one-cycle valid pulse into the RX CDC FIFO write port, and reports parity and framing errors alongside.

---
 rtl/uart_rx_framer.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_framer.sv
// UART receive framer: oversampled start detection and 8-bit LSB-first deserialization with optional parity and 1/2 stop bits.
// Define UART_RX_MAJORITY_EN to evaluate each bit as a 2-of-3 majority around mid-bit instead of a single sample.
module uart_rx_framer #(
    parameter int SYNC_STAGES = 2,
    parameter int OVERSAMPLE  = 8
) (
    input  logic       clk_i,
    input  logic       arst_i,
    input  logic       cfg_parity_en_i,
    input  logic       cfg_parity_type_i,
    input  logic       cfg_stop_bits_i,
    input  logic       rx_i,
    output logic [7:0] rx_data_o,
    output logic       rx_data_valid_o,
    output logic       parity_err_o,
    output logic       frame_err_o,
    output logic       busy_o
);
    localparam int CW  = $clog2(OVERSAMPLE);
    localparam int MID = OVERSAMPLE / 2;
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLE - 1);
    localparam logic [CW-1:0] CNT_EVAL = CW'(MID + 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP1,
        STOP2,
        WAIT_IDLE
    } state_t;

    state_t               state;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                 rx_s;
    logic [CW-1:0]        cnt;
    logic [2:0]           bit_idx;
    logic [7:0]           shift_q;
    logic                 par_en_q;
    logic                 par_type_q;
    logic                 stop2_q;
    logic                 par_flag;
    logic                 stop_done;
    logic                 bit_val;
    logic                 final_stop;

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rx_i};
        end
    end

    assign rx_s = sync_q[SYNC_STAGES-1];

`ifdef UART_RX_MAJORITY_EN
    logic samp_a;
    logic samp_b;

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            samp_a <= 1'b1;
            samp_b <= 1'b1;
        end else begin
            if (cnt == CW'(MID - 1)) samp_a <= rx_s;
            if (cnt == CW'(MID))     samp_b <= rx_s;
        end
    end

    // Third vote is the live sample at the evaluation count.
    assign bit_val = (samp_a & samp_b) | (samp_a & rx_s) | (samp_b & rx_s);
`else
    logic samp_b;

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            samp_b <= 1'b1;
        end else if (cnt == CW'(MID)) begin
            samp_b <= rx_s;
        end
    end

    assign bit_val = samp_b;
`endif

    assign final_stop = (state == STOP2) || !stop2_q;

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state           <= IDLE;
            cnt             <= '0;
            bit_idx         <= '0;
            shift_q         <= '0;
            par_en_q        <= 1'b0;
            par_type_q      <= 1'b0;
            stop2_q         <= 1'b0;
            par_flag        <= 1'b0;
            stop_done       <= 1'b0;
            rx_data_o       <= '0;
            rx_data_valid_o <= 1'b0;
            parity_err_o    <= 1'b0;
            frame_err_o     <= 1'b0;
            busy_o          <= 1'b0;
        end else begin
            rx_data_valid_o <= 1'b0;
            parity_err_o    <= 1'b0;
            frame_err_o     <= 1'b0;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (!rx_s) begin
                        state      <= START;
                        busy_o     <= 1'b1;
                        cnt        <= CNT_ONE;
                        par_en_q   <= cfg_parity_en_i;
                        par_type_q <= cfg_parity_type_i;
                        stop2_q    <= cfg_stop_bits_i;
                        bit_idx    <= '0;
                        par_flag   <= 1'b0;
                        stop_done  <= 1'b0;
                    end
                end
                START: begin
                    cnt <= cnt + CNT_ONE;
                    if (cnt == CNT_LAST) state <= DATA;
                    if (cnt == CNT_EVAL && bit_val) begin
                        state  <= IDLE;
                        busy_o <= 1'b0;
                        cnt    <= '0;
                    end
                end
                DATA: begin
                    cnt <= cnt + CNT_ONE;
                    if (cnt == CNT_EVAL) shift_q <= {bit_val, shift_q[7:1]};
                    if (cnt == CNT_LAST) begin
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) state <= par_en_q ? PARITY : STOP1;
                    end
                end
                PARITY: begin
                    cnt <= cnt + CNT_ONE;
                    if (cnt == CNT_EVAL) par_flag <= bit_val ^ (^shift_q) ^ par_type_q;
                    if (cnt == CNT_LAST) state <= STOP1;
                end
                STOP1, STOP2: begin
                    // A good final stop returns to IDLE one cycle after the pulse, well before the bit ends.
                    if (stop_done) begin
                        state  <= IDLE;
                        busy_o <= 1'b0;
                        cnt    <= '0;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                        if (cnt == CNT_LAST && !final_stop) state <= STOP2;
                        if (cnt == CNT_EVAL) begin
                            if (!bit_val) begin
                                frame_err_o <= 1'b1;
                                state       <= WAIT_IDLE;
                                cnt         <= '0;
                            end else if (final_stop) begin
                                rx_data_o       <= shift_q;
                                rx_data_valid_o <= 1'b1;
                                parity_err_o    <= par_flag;
                                stop_done       <= 1'b1;
                            end
                        end
                    end
                end
                WAIT_IDLE: begin
                    cnt <= '0;
                    if (rx_s) begin
                        state  <= IDLE;
                        busy_o <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_o <= 1'b0;
                    cnt    <= '0;
                end
            endcase
        end
    end
endmodule
